// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: types and default widths shared by the in-order pipeline stage latches.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int IR_W_DEF  = 32;
  localparam int PC_W_DEF  = 32;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_stall_ctr.sv
// pipe_stall_ctr: saturating event counter for pipeline perf monitors.
// Cleared only by reset; holds at all-ones once full.
import cpu_pipe_pkg::*;

module pipe_stall_ctr #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready stage latch carrying IR and PC, with flush and stall counter.
// Define PIPE_SKID_EN to build the two-entry skid buffer with a registered in_ready.
import cpu_pipe_pkg::*;

module pipe_stage_buf #(
  parameter int IR_W  = IR_W_DEF,
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IR_W-1:0]  in_ir,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IR_W-1:0]  out_ir,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t     state_q, state_d;
  logic [IR_W-1:0] main_ir_q, main_ir_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d;
  logic            accept;
  logic            pop;

  assign out_valid = (state_q != EMPTY);
  assign out_ir    = main_ir_q;
  assign out_pc    = main_pc_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic [IR_W-1:0] skid_ir_q, skid_ir_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            in_ready_q;

  // in_ready comes straight from a flop, so out_ready never reaches upstream combinationally.
  assign in_ready = in_ready_q;

  always_comb begin
    state_d   = state_q;
    main_ir_d = main_ir_q;
    main_pc_d = main_pc_q;
    skid_ir_d = skid_ir_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      state_d   = EMPTY;
      main_ir_d = '0;
      main_pc_d = '0;
      skid_ir_d = '0;
      skid_pc_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ir_d = in_ir;
            main_pc_d = in_pc;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ir_d = in_ir;
            main_pc_d = in_pc;
          end else if (accept) begin
            skid_ir_d = in_ir;
            skid_pc_d = in_pc;
            state_d   = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_ir_d = skid_ir_q;
            main_pc_d = skid_pc_q;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_ir_q  <= '0;
      skid_pc_q  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_ir_q  <= skid_ir_d;
      skid_pc_q  <= skid_pc_d;
      in_ready_q <= (state_d != TWO);
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_d   = state_q;
    main_ir_d = main_ir_q;
    main_pc_d = main_pc_q;
    if (flush) begin
      state_d   = EMPTY;
      main_ir_d = '0;
      main_pc_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ir_d = in_ir;
            main_pc_d = in_pc;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept) begin
            main_ir_d = in_ir;
            main_pc_d = in_pc;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_ir_q <= '0;
      main_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      main_ir_q <= main_ir_d;
      main_pc_q <= main_pc_d;
    end
  end

  pipe_stall_ctr #(
    .CNT_W(CNT_W)
  ) u_stall_ctr (
    .clk_i (clk),
    .rst_ni(rst_n),
    .inc_i (out_valid && !out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: table vectors, directed corner sequences and a random run checked
// against a queue-based model of the stage (capacity 2 with PIPE_SKID_EN, else 1).
module tb_pipe_stage_buf;

  localparam int IR_W    = 32;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IR_W-1:0]  in_ir;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [IR_W-1:0]  out_ir;
  logic [PC_W-1:0]  out_pc;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: held entries in FIFO order, the value left on out_* when empty, stall count.
  logic [63:0] modelQ[$];
  logic [63:0] staleVal;
  int          modelCnt;

  typedef struct {
    bit          inValid;
    logic [31:0] ir;
    logic [31:0] pc;
    bit          expValid;
    logic [31:0] expIr;
    logic [31:0] expPc;
    bit          expReady;
    int          expCnt;
  } vec_t;

  vec_t vecs[6];

  pipe_stage_buf #(
    .IR_W (IR_W),
    .PC_W (PC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ir    (in_ir),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ir   (out_ir),
    .out_pc   (out_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit r, input bit f, input logic [31:0] ir, input logic [31:0] pc);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_ir     = ir;
    in_pc     = pc;
  endtask

  function automatic bit modelReady();
    if (SKID) return modelQ.size() < 2;
    return (modelQ.size() == 0) || out_ready;
  endfunction

  task automatic checkModel();
    logic [63:0] head;
    head = (modelQ.size() > 0) ? modelQ[0] : staleVal;
    checkOutput("out_valid", 64'(out_valid), 64'(modelQ.size() > 0));
    checkOutput("out_ir", 64'(out_ir), 64'(head[63:32]));
    checkOutput("out_pc", 64'(out_pc), 64'(head[31:0]));
    checkOutput("in_ready", 64'(in_ready), 64'(modelReady()));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(modelCnt));
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic cycle();
    bit acc, popB, inc;
    #1;
    checkModel();
    acc  = in_valid && modelReady();
    popB = (modelQ.size() > 0) && out_ready;
    inc  = (modelQ.size() > 0) && !out_ready;
    @(posedge clk);
    if (inc && modelCnt < CNT_MAX) modelCnt++;
    if (flush) begin
      modelQ.delete();
      staleVal = '0;
    end else begin
      if (popB) staleVal = modelQ.pop_front();
      if (acc) modelQ.push_back({in_ir, in_pc});
    end
    @(negedge clk);
  endtask

  task automatic modelReset();
    modelQ.delete();
    staleVal = '0;
    modelCnt = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    modelReset();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, '0, '0);
    modelReset();

    vecs[0] = '{1, 32'h11, 32'h0, 0, 32'h0,  32'h0, 1, 0};
    vecs[1] = '{1, 32'h22, 32'h4, 1, 32'h11, 32'h0, 1, 0};
    vecs[2] = '{1, 32'h33, 32'h8, 1, 32'h22, 32'h4, 1, 0};
    vecs[3] = '{1, 32'h44, 32'hC, 1, 32'h33, 32'h8, 1, 0};
    vecs[4] = '{0, 32'h0,  32'h0, 1, 32'h44, 32'hC, 1, 0};
    vecs[5] = '{0, 32'h0,  32'h0, 0, 32'h44, 32'hC, 1, 0};

    @(negedge clk);
    doReset();

    // Streaming at full rate with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].inValid, 1, 0, vecs[i].ir, vecs[i].pc);
      #1;
      checkOutput("vec_valid", 64'(out_valid), 64'(vecs[i].expValid));
      checkOutput("vec_ir", 64'(out_ir), 64'(vecs[i].expIr));
      checkOutput("vec_pc", 64'(out_pc), 64'(vecs[i].expPc));
      checkOutput("vec_ready", 64'(in_ready), 64'(vecs[i].expReady));
      checkOutput("vec_cnt", 64'(stall_cnt), 64'(vecs[i].expCnt));
      cycle();
    end

`ifdef PIPE_SKID_EN
    // Backpressure: two entries fit, the third is held off, then drain in order.
    doReset();
    applyStimulus(1, 0, 0, 32'hA0, 32'h0);
    cycle();
    applyStimulus(1, 0, 0, 32'hA1, 32'h4);
    cycle();
    applyStimulus(1, 0, 0, 32'hA2, 32'h8);
    #1;
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_cnt1", 64'(stall_cnt), 64'd1);
    cycle();
    checkOutput("bp_cnt2", 64'(stall_cnt), 64'd2);
    applyStimulus(0, 1, 0, '0, '0);
    #1;
    checkOutput("bp_first_pc", 64'(out_pc), 64'h0);
    cycle();
    checkOutput("bp_second_pc", 64'(out_pc), 64'h4);
    cycle();
    checkOutput("bp_drained", 64'(out_valid), 64'd0);
    cycle();
`else
    // Without the skid, in_ready follows out_ready combinationally while full.
    doReset();
    applyStimulus(1, 0, 0, 32'hB0, 32'h0);
    cycle();
    applyStimulus(0, 0, 0, '0, '0);
    #1;
    checkOutput("comb_ready_lo", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("comb_ready_hi", 64'(in_ready), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 1, 0, 32'hB0 + 32'(i), 32'(i * 4));
      #1;
      checkOutput("thru_ready", 64'(in_ready), 64'd1);
      cycle();
      checkOutput("thru_pc", 64'(out_pc), 64'(i * 4));
    end
    applyStimulus(0, 1, 0, '0, '0);
    cycle();
`endif

    // Flush while full, with a new entry offered in the same cycle.
    doReset();
    applyStimulus(1, 0, 0, 32'h51, 32'h10);
    cycle();
    applyStimulus(1, 0, 0, 32'h52, 32'h14);
    cycle();
    applyStimulus(1, 0, 1, 32'h99, 32'h99);
    cycle();
    applyStimulus(0, 1, 0, '0, '0);
    #1;
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ir", 64'(out_ir), 64'd0);
    checkOutput("flush_pc", 64'(out_pc), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    repeat (3) cycle();

    // Stall counter saturation.
    doReset();
    applyStimulus(1, 0, 0, 32'h61, 32'h20);
    cycle();
    applyStimulus(0, 0, 0, '0, '0);
    repeat (20) cycle();
    checkOutput("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));

    // Asynchronous reset while full and stalled.
    applyStimulus(1, 0, 0, 32'h71, 32'h30);
    cycle();
    applyStimulus(0, 0, 0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_ir", 64'(out_ir), 64'd0);
    checkOutput("arst_pc", 64'(out_pc), 64'd0);
    checkOutput("arst_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 32'h81, 32'h40);
    cycle();
    checkOutput("post_rst_ir", 64'(out_ir), 64'h81);
    applyStimulus(1, 1, 0, 32'h82, 32'h44);
    cycle();
    applyStimulus(0, 1, 0, '0, '0);
    cycle();

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, $urandom, $urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
